// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: request/result handshake plus the alu operand/control/result
// bus between the multiply sequencer and the downstream alu.
interface alu_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zx;
    logic             alu_nx;
    logic             alu_zy;
    logic             alu_ny;
    logic             alu_f;
    logic             alu_no;
    logic [WIDTH-1:0] alu_out;

    // requester side; it also closes the loop by returning the alu result
    modport master (
        output start, a, b, alu_out,
        input  busy, done, result,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
    );

    // sequencer side
    modport slave (
        input  start, a, b, alu_out,
        output busy, done, result,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier that borrows the downstream alu
// for its additions. One partial-product step per RUN cycle; returns the low
// WIDTH bits of a*b (identical for signed and unsigned operands).
// Optional feature: define MUL_EARLY_EXIT_EN to stop as soon as the remaining
// multiplier bits are all zero.
module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // alu control words {zx,nx,zy,ny,f,no}
    localparam logic [5:0] CTRL_ZERO = 6'b101010;
    localparam logic [5:0] CTRL_ADD  = 6'b000010;
    localparam logic [5:0] CTRL_X    = 6'b001100;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, mcand, mplier, result_q;
    logic [CNT_W-1:0] cnt;
    logic             busy_q, done_q;
    logic             last_step;
    logic [5:0]       ctrl;
    logic [WIDTH-1:0] alu_x_c, alu_y_c;

`ifdef MUL_EARLY_EXIT_EN
    // nothing left to add once the shifted multiplier is zero
    assign last_step = (cnt == CNT_W'(WIDTH-1)) || ((mplier >> 1) == '0);
`else
    assign last_step = (cnt == CNT_W'(WIDTH-1));
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and alu operand/control decode
    always_comb begin
        state_nx = state;
        alu_x_c  = '0;
        alu_y_c  = '0;
        ctrl     = CTRL_ZERO;
        case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN: begin
                alu_x_c = acc;
                alu_y_c = mcand;
                ctrl    = mplier[0] ? CTRL_ADD : CTRL_X;
                if (last_step) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: operand capture, one shift-add step per RUN cycle, result latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nx == RUN);
            done_q <= (state_nx == DONE);
            case (state)
                IDLE: if (bus.start) begin
                    acc      <= '0;
                    mcand    <= bus.a;
                    mplier   <= bus.b;
                    cnt      <= '0;
                    result_q <= '0;
                end
                RUN: begin
                    acc    <= bus.alu_out;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) result_q <= bus.alu_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.alu_x  = alu_x_c;
    assign bus.alu_y  = alu_y_c;
    assign bus.alu_zx = ctrl[5];
    assign bus.alu_nx = ctrl[4];
    assign bus.alu_zy = ctrl[3];
    assign bus.alu_ny = ctrl[2];
    assign bus.alu_f  = ctrl[1];
    assign bus.alu_no = ctrl[0];
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench for alu_mul_seq with a full-function alu
// model closing the loop; the alu bus is checked after every clock edge.
module tb_alu_mul_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;

    alu_mul_seq_if #(.WIDTH(16)) bus ();

    alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // general alu model: zero/negate each input, add or and, negate output
    logic [15:0] mx, my, mo;
    always_comb begin
        mx = bus.alu_zx ? 16'h0 : bus.alu_x;
        mx = bus.alu_nx ? ~mx : mx;
        my = bus.alu_zy ? 16'h0 : bus.alu_y;
        my = bus.alu_ny ? ~my : my;
        mo = bus.alu_f ? (mx + my) : (mx & my);
        bus.alu_out = bus.alu_no ? ~mo : mo;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge, then check the alu bus settles to a legal operation
    task automatic tick();
        logic [5:0]  c;
        logic [15:0] e;
        @(posedge clk);
        #1;
        c = {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};
        chk("ctrl_legal", {31'd0, (c == 6'b101010 || c == 6'b000010 || c == 6'b001100)}, 32'd1);
        case (c)
            6'b000010: e = bus.alu_x + bus.alu_y;
            6'b001100: e = bus.alu_x;
            default:   e = 16'h0;
        endcase
        chk("alu_out", {16'd0, bus.alu_out}, {16'd0, e});
    endtask

    function automatic int run_len(input logic [15:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int n = 1;
        for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
        return n;
`else
        return 16;
`endif
    endfunction

    // launch one multiply and check result, latency, busy length, single done
    task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp);
        int n = 0;
        int busy_n = 0;
        bit seen = 0;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (bus.busy) busy_n++;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (bus.busy) busy_n++;
            if (bus.done) seen = 1;
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_latency"}, n, run_len(b));
        chk({tag, "_busy_cycles"}, busy_n, run_len(b));
        chk({tag, "_result"}, {16'd0, bus.result}, {16'd0, exp});
        tick();
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_result_held"}, {16'd0, bus.result}, {16'd0, exp});
    endtask

    initial begin
        int dn;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_result", {16'd0, bus.result}, 32'd0);
        rst_n = 1'b1;
        tick();

        do_mul("m3x5", 16'd3, 16'd5, 16'd15);
        do_mul("mffff", 16'hFFFF, 16'hFFFF, 16'h0001);
        do_mul("m300", 16'd300, 16'd300, 16'h5F90);
        do_mul("mneg", 16'hFFFD, 16'd5, 16'hFFF1);
        do_mul("movf", 16'h8000, 16'd2, 16'h0000);
        do_mul("mtop", 16'd1, 16'h8000, 16'h8000);

        // second start during RUN must be ignored
        bus.a = 16'd2;
        bus.b = 16'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.a = 16'd9;
        bus.b = 16'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done) dn++;
        end
        chk("ign_done_pulses", dn, 1);
        chk("ign_result", {16'd0, bus.result}, 32'd6);

        // reset mid-RUN discards the operation
        bus.a = 16'd5;
        bus.b = 16'h8001;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_result", {16'd0, bus.result}, 32'd0);
        tick();
        do_mul("m4x4", 16'd4, 16'd4, 16'd16);

`ifdef MUL_EARLY_EXIT_EN
        do_mul("ee7x2", 16'd7, 16'd2, 16'd14);
        do_mul("ee7x0", 16'd7, 16'd0, 16'd0);
`else
        do_mul("m7x0", 16'd7, 16'd0, 16'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
